// File: rtl/logaritmo_entero.sv
// Sequential integer logarithm: resultado = floor(log_base(valor)), exacto when base**resultado == valor.
// Latency: listo pulses k+2 cycles after the accepting edge (1 cycle for invalid operands).
// Backpressure: none; inicio is ignored while ocupado is high, requests are not queued.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   inicio_i     start request, sampled only when idle
//   base_i       logarithm base, captured on accept
//   valor_i      argument, captured on accept
//   resultado_o  floor(log_base(valor)), held until the next completion
//   exacto_o     base**resultado == valor
//   error_o      base < 2 or valor == 0
//   listo_o      one-cycle done pulse
//   ocupado_o    computation in progress (CALCULO or FIN)
module logaritmo_entero #(
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inicio_i,
  input  logic [M-1:0] base_i,
  input  logic [M-1:0] valor_i,
  output logic [M-1:0] resultado_o,
  output logic         exacto_o,
  output logic         error_o,
  output logic         listo_o,
  output logic         ocupado_o
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [M-1:0]     base_q, base_d;
  logic [M-1:0]     valor_q, valor_d;
  logic [2*M-1:0]   acum_q, acum_d;
  logic [M-1:0]     cuenta_q, cuenta_d;
  logic [M-1:0]     resultado_q, resultado_d;
  logic             exacto_q, exacto_d;
  logic             error_q, error_d;
  logic             listo_q, listo_d;

  logic [2*M-1:0]   base_ext;
  logic [2*M-1:0]   valor_ext;
  logic [2*M-1:0]   producto;
  logic             entrada_invalida;

  // acum never exceeds valor (< 2^M), so a 2M-bit product cannot wrap.
  assign base_ext  = {{M{1'b0}}, base_q};
  assign valor_ext = {{M{1'b0}}, valor_q};
  assign producto  = acum_q * base_ext;

  // base < 2 means every bit above bit 0 is clear.
  assign entrada_invalida = (base_i[M-1:1] == '0) || (valor_i == '0);

  always_comb begin
    estado_d    = estado_q;
    base_d      = base_q;
    valor_d     = valor_q;
    acum_d      = acum_q;
    cuenta_d    = cuenta_q;
    resultado_d = resultado_q;
    exacto_d    = exacto_q;
    error_d     = error_q;
    // listo is registered off the FIN state, so it appears in the first
    // idle cycle after FIN, when resultado/exacto/error are already stable.
    listo_d     = (estado_q == FIN);

    case (estado_q)
      REPOSO: begin
        if (inicio_i) begin
          base_d   = base_i;
          valor_d  = valor_i;
          acum_d   = (2*M)'(1);
          cuenta_d = '0;
          if (entrada_invalida) begin
            resultado_d = '0;
            exacto_d    = 1'b0;
            error_d     = 1'b1;
            estado_d    = FIN;
          end else begin
            estado_d = CALCULO;
          end
        end
      end

      CALCULO: begin
        if (producto <= valor_ext) begin
          acum_d   = producto;
          cuenta_d = cuenta_q + M'(1);
        end else begin
          resultado_d = cuenta_q;
          exacto_d    = (acum_q == valor_ext);
          error_d     = 1'b0;
          estado_d    = FIN;
        end
      end

      FIN: begin
        estado_d = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q    <= REPOSO;
      base_q      <= '0;
      valor_q     <= '0;
      acum_q      <= '0;
      cuenta_q    <= '0;
      resultado_q <= '0;
      exacto_q    <= 1'b0;
      error_q     <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      base_q      <= base_d;
      valor_q     <= valor_d;
      acum_q      <= acum_d;
      cuenta_q    <= cuenta_d;
      resultado_q <= resultado_d;
      exacto_q    <= exacto_d;
      error_q     <= error_d;
      listo_q     <= listo_d;
    end
  end

  assign resultado_o = resultado_q;
  assign exacto_o    = exacto_q;
  assign error_o     = error_q;
  assign listo_o     = listo_q;
  assign ocupado_o   = (estado_q != REPOSO);

endmodule
